// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage with stall hold, pending branch target and flush/abort of in-flight requests.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_flag,
    input  logic [31:0] br_addr,
    output logic        ibus_en,
    output logic [31:0] ibus_addr,
    input  logic [31:0] ibus_rdata,
    input  logic        ibus_ack,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcp4,
    output logic [31:0] if_inst,
    output logic [3:0]  if_excp,
    output logic        if_stallreq
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, ABORT} state_t;
    state_t state, state_nxt;
    logic [31:0] pc, inst_buf, pend_addr, redir_addr, next_pc;
    logic pend, misal, valid, handoff;

    assign misal = pc[1:0] != 2'b00;
    assign valid = (state == FETCH && (ibus_ack || misal)) || state == HOLD;
    assign handoff = valid && !stall && !flush;
    assign ibus_en = (state == FETCH && !misal) || state == ABORT;
    assign ibus_addr = pc;
    assign if_pc = pc;
    assign if_pcp4 = pc + 32'd4;
    assign if_inst = (state == FETCH && ibus_ack && !misal) ? ibus_rdata : (state == HOLD) ? inst_buf : 32'd0;
    assign if_excp = ((state == FETCH || state == HOLD) && misal) ? 4'd1 : 4'd0;
    assign if_stallreq = state == BOOT || state == ABORT || (state == FETCH && !valid);
    assign next_pc = br_flag ? br_addr : pend ? pend_addr : pc + 32'd4;

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = (ibus_en && !ibus_ack) ? ABORT : FETCH;
        else if (handoff || state == BOOT || (state == ABORT && ibus_ack))
            state_nxt = FETCH;
        else if (state == FETCH && valid)
            state_nxt = HOLD;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    // An in-flight request cannot be cancelled, so a flush during it parks the target in redir_addr.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 32'hBFC0_0000;
            pend <= 1'b0;
            pend_addr <= 32'd0;
            inst_buf <= 32'd0;
            redir_addr <= 32'd0;
        end else if (flush) begin
            pend <= 1'b0;
            if (ibus_en && !ibus_ack)
                redir_addr <= flush_pc;
            else
                pc <= flush_pc;
        end else if (handoff) begin
            pc <= next_pc;
            pend <= 1'b0;
        end else begin
            if (br_flag && state != ABORT) begin
                pend <= 1'b1;
                pend_addr <= br_addr;
            end
            if (state == FETCH && valid)
                inst_buf <= if_inst;
            if (state == ABORT && ibus_ack)
                pc <= redir_addr;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vector table, hand sequences and randomized run against a transaction-level model.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst, stall, flush, br_flag, ibus_ack;
    logic [31:0] flush_pc, br_addr, ibus_rdata;
    logic        ibus_en, if_stallreq;
    logic [31:0] ibus_addr, if_pc, if_pcp4, if_inst;
    logic [3:0]  if_excp;
    int n_cmp = 0;
    int n_err = 0;

    inst_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .br_flag(br_flag), .br_addr(br_addr), .ibus_en(ibus_en), .ibus_addr(ibus_addr),
        .ibus_rdata(ibus_rdata), .ibus_ack(ibus_ack), .if_pc(if_pc), .if_pcp4(if_pcp4),
        .if_inst(if_inst), .if_excp(if_excp), .if_stallreq(if_stallreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r, s, f;
        logic [31:0] fpc;
        bit b;
        logic [31:0] baddr;
        bit a;
        logic [31:0] rd;
        bit e_en;
        logic [31:0] e_addr, e_pc, e_inst;
        logic [3:0] e_excp;
        bit e_sreq;
    } vec_t;
    vec_t tbl[28];

    bit m_boot, m_abort, m_held, m_pend;
    logic [31:0] m_pc, m_buf, m_redir, m_paddr;
    bit e_en, e_valid, e_sreq;
    logic [31:0] e_inst;
    logic [3:0] e_excp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit f, input logic [31:0] fpc,
                         input bit b, input logic [31:0] baddr, input bit a, input logic [31:0] rd);
        rst = r; stall = s; flush = f; flush_pc = fpc;
        br_flag = b; br_addr = baddr; ibus_ack = a; ibus_rdata = rd;
        #1;
    endtask

    task automatic chk_all(input string tag, input bit en, input logic [31:0] addr, input logic [31:0] pc,
                           input logic [31:0] inst, input logic [3:0] excp, input bit sreq);
        chk({tag, " en"}, 32'(ibus_en), 32'(en));
        if (en) chk({tag, " addr"}, ibus_addr, addr);
        chk({tag, " pc"}, if_pc, pc);
        chk({tag, " pcp4"}, if_pcp4, pc + 32'd4);
        chk({tag, " inst"}, if_inst, inst);
        chk({tag, " excp"}, 32'(if_excp), 32'(excp));
        chk({tag, " stallreq"}, 32'(if_stallreq), 32'(sreq));
    endtask

    task automatic model_out();
        e_valid = 0; e_en = 0; e_inst = 0; e_excp = 0; e_sreq = 0;
        if (m_boot) e_sreq = 1;
        else if (m_abort) begin e_en = 1; e_sreq = 1; end
        else if (m_held) begin e_valid = 1; e_inst = m_buf; e_excp = (m_pc % 4 != 0) ? 4'd1 : 4'd0; end
        else if (m_pc % 4 != 0) begin e_valid = 1; e_excp = 1; end
        else begin
            e_en = 1;
            if (ibus_ack) begin e_valid = 1; e_inst = ibus_rdata; end
            else e_sreq = 1;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_boot = 1; m_abort = 0; m_held = 0; m_pend = 0; m_pc = 32'hBFC0_0000; m_buf = 0;
        end else if (flush) begin
            m_pend = 0; m_held = 0; m_boot = 0;
            if (e_en && !ibus_ack) begin m_abort = 1; m_redir = flush_pc; end
            else begin m_abort = 0; m_pc = flush_pc; end
        end else if (m_abort) begin
            if (ibus_ack) begin m_abort = 0; m_pc = m_redir; end
        end else if (e_valid && !stall) begin
            m_pc = br_flag ? br_addr : m_pend ? m_paddr : m_pc + 4;
            m_pend = 0; m_held = 0;
        end else begin
            if (br_flag) begin m_pend = 1; m_paddr = br_addr; end
            if (e_valid) begin m_held = 1; m_buf = e_inst; end
            m_boot = 0;
        end
    endtask

    initial begin
        tbl[0]  = '{1,0,0,0,0,0,0,0,                                   0,0,32'hBFC00000,0,0,1};
        tbl[1]  = '{0,0,0,0,0,0,0,0,                                   0,0,32'hBFC00000,0,0,1};
        tbl[2]  = '{0,0,0,0,0,0,1,32'h11111111,                        1,32'hBFC00000,32'hBFC00000,32'h11111111,0,0};
        tbl[3]  = '{0,0,0,0,0,0,0,0,                                   1,32'hBFC00004,32'hBFC00004,0,0,1};
        tbl[4]  = '{0,0,0,0,0,0,0,0,                                   1,32'hBFC00004,32'hBFC00004,0,0,1};
        tbl[5]  = '{0,0,0,0,0,0,0,0,                                   1,32'hBFC00004,32'hBFC00004,0,0,1};
        tbl[6]  = '{0,0,0,0,0,0,1,32'h22222222,                        1,32'hBFC00004,32'hBFC00004,32'h22222222,0,0};
        tbl[7]  = '{0,0,0,0,0,0,1,32'h33333333,                        1,32'hBFC00008,32'hBFC00008,32'h33333333,0,0};
        tbl[8]  = '{0,1,0,0,0,0,1,32'h24020001,                        1,32'hBFC0000C,32'hBFC0000C,32'h24020001,0,0};
        tbl[9]  = '{0,1,0,0,0,0,0,0,                                   0,0,32'hBFC0000C,32'h24020001,0,0};
        tbl[10] = '{0,0,0,0,0,0,0,0,                                   0,0,32'hBFC0000C,32'h24020001,0,0};
        tbl[11] = '{0,0,0,0,1,32'h80001000,0,0,                        1,32'hBFC00010,32'hBFC00010,0,0,1};
        tbl[12] = '{0,0,0,0,0,0,1,32'h44444444,                        1,32'hBFC00010,32'hBFC00010,32'h44444444,0,0};
        tbl[13] = '{0,0,0,0,0,0,1,32'h55555555,                        1,32'h80001000,32'h80001000,32'h55555555,0,0};
        tbl[14] = '{0,0,1,32'hBFC00380,0,0,0,0,                        1,32'h80001004,32'h80001004,0,0,1};
        tbl[15] = '{0,0,0,0,0,0,0,0,                                   1,32'h80001004,32'h80001004,0,0,1};
        tbl[16] = '{0,0,0,0,0,0,1,32'h66666666,                        1,32'h80001004,32'h80001004,0,0,1};
        tbl[17] = '{0,0,0,0,0,0,1,32'h77777777,                        1,32'hBFC00380,32'hBFC00380,32'h77777777,0,0};
        tbl[18] = '{0,0,1,32'hBFC00380,0,0,1,32'h88888888,             1,32'hBFC00384,32'hBFC00384,32'h88888888,0,0};
        tbl[19] = '{0,0,0,0,0,0,1,32'h99999999,                        1,32'hBFC00380,32'hBFC00380,32'h99999999,0,0};
        tbl[20] = '{0,0,0,0,1,32'h80000002,1,32'hAAAAAAAA,             1,32'hBFC00384,32'hBFC00384,32'hAAAAAAAA,0,0};
        tbl[21] = '{0,0,0,0,0,0,0,0,                                   0,0,32'h80000002,0,1,0};
        tbl[22] = '{0,0,0,0,1,32'hFFFFFFFC,0,0,                        0,0,32'h80000006,0,1,0};
        tbl[23] = '{0,0,0,0,0,0,0,0,                                   1,32'hFFFFFFFC,32'hFFFFFFFC,0,0,1};
        tbl[24] = '{0,0,0,0,0,0,1,32'hBBBBBBBB,                        1,32'hFFFFFFFC,32'hFFFFFFFC,32'hBBBBBBBB,0,0};
        tbl[25] = '{1,0,0,0,0,0,0,0,                                   1,32'h00000000,32'h00000000,0,0,1};
        tbl[26] = '{0,0,0,0,0,0,0,0,                                   0,0,32'hBFC00000,0,0,1};
        tbl[27] = '{0,0,0,0,0,0,1,32'h12345678,                        1,32'hBFC00000,32'hBFC00000,32'h12345678,0,0};

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].fpc, tbl[i].b, tbl[i].baddr, tbl[i].a, tbl[i].rd);
            chk_all($sformatf("row%0d", i), tbl[i].e_en, tbl[i].e_addr, tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_excp, tbl[i].e_sreq);
            @(negedge clk);
        end

        // reset while an aborted request is still outstanding
        drive(0, 0, 1, 32'hBFC00380, 0, 0, 0, 0);
        chk_all("rstabort_flush", 1, 32'hBFC00004, 32'hBFC00004, 0, 0, 1);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk_all("rstabort_abort", 1, 32'hBFC00004, 32'hBFC00004, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        chk_all("rstabort_boot", 0, 0, 32'hBFC00000, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D);
        chk_all("rstabort_fetch", 1, 32'hBFC00000, 32'hBFC00000, 32'h0BADF00D, 0, 0);
        @(negedge clk);

        // branch resolved while the instruction is held by a stall
        drive(0, 1, 0, 0, 0, 0, 1, 32'hCAFE0001);
        chk_all("holdbr_cap", 1, 32'hBFC00004, 32'hBFC00004, 32'hCAFE0001, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 0, 1, 32'h80002000, 0, 0);
        chk_all("holdbr_br", 0, 0, 32'hBFC00004, 32'hCAFE0001, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_all("holdbr_go", 0, 0, 32'hBFC00004, 32'hCAFE0001, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_all("holdbr_tgt", 1, 32'h80002000, 32'h80002000, 0, 0, 1);
        @(negedge clk);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        model_step();
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ba;
            ba = $urandom;
            if ($urandom_range(0, 9) != 0) ba[1:0] = 2'b00;
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 7) == 0, ba, $urandom_range(0, 1) == 1, $urandom);
            model_out();
            chk_all($sformatf("rnd%0d", i), e_en, m_pc, m_pc, e_inst, e_excp, e_sreq);
            model_step();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 stall  in  1  IF/ID register not accepting this cycle.
REQ-004 flush  in  1  pipeline flush (exception/ERET); redirect to flush_pc.
REQ-005 flush_pc  in  32  flush target address.
REQ-006 br_flag  in  1  ID stage resolved taken branch/jump.
REQ-007 br_addr  in  32  branch target.
REQ-008 ibus_en  out  1  instruction bus request.
REQ-009 ibus_addr  out  32  request address.
REQ-010 ibus_rdata  in  32  read data, valid only with ibus_ack.
REQ-011 ibus_ack  in  1  transaction complete; may arrive same cycle as request or later.
REQ-012 if_pc, if_pcp4  out  32 each  PC of fetched instruction and PC+4.
REQ-013 if_inst  out  32  fetched instruction word.
REQ-014 if_excp  out  4  exception code: 0 = none, 1 = AdEL (fetch address error).
REQ-015 if_stallreq  out  1  fetch not yet valid; request pipeline stall.

Function
REQ-016 Registers: pc (32), state in {BOOT, FETCH, HOLD, ABORT}, inst_buf (32), pend (1), pend_addr (32), redir_addr (32).
REQ-017 if_pc = pc; if_pcp4 = pc + 4 modulo 2^32 (0xFFFFFFFC -> 0x00000000); ibus_addr = pc in FETCH, = redir-aborted address (held pc) in ABORT.
REQ-018 Valid instruction this cycle ("valid"): FETCH with ibus_ack, FETCH with pc[1:0] != 0, or HOLD.
REQ-019 Handoff = valid && !stall && !flush.
REQ-020 ibus_en = 1 in FETCH when pc[1:0] == 0; = 1 in ABORT; else 0; request held with constant address until ibus_ack.
REQ-021 Misaligned pc: no bus request; if_inst = 0, if_excp = 1, valid immediately.
REQ-022 if_inst = ibus_rdata in FETCH with ack; inst_buf in HOLD; 0 otherwise. if_excp = 0 unless REQ-021.
REQ-023 if_stallreq = 1 in BOOT, ABORT, and FETCH when !valid; 0 otherwise.
REQ-024 BOOT -> FETCH after one cycle, pc unchanged.
REQ-025 FETCH: handoff -> pc <= next, stay FETCH; valid && stall && !flush -> inst_buf <= if_inst (excp status kept by pc alignment), HOLD.
REQ-026 HOLD: handoff -> pc <= next, FETCH; stall -> remain, inst_buf unchanged.
REQ-027 next = br_addr if br_flag this cycle; else pend_addr if pend; else pc + 4. Handoff clears pend.
REQ-028 br_flag without handoff: pend <= 1, pend_addr <= br_addr (later assertion overwrites; repeated same value idempotent).
REQ-029 Flush (priority over everything but rst): pend <= 0; discard current instruction; if ibus_en=1 and ibus_ack=0 this cycle -> redir_addr <= flush_pc, ABORT; else pc <= flush_pc, FETCH.
REQ-030 ABORT: keep request until ibus_ack; data discarded; on ack pc <= redir_addr, FETCH. Flush in ABORT overwrites redir_addr. br_flag in ABORT ignored.
REQ-031 No instruction is ever delivered twice or skipped except by flush/branch redirect.

Reset
REQ-032 rst: pc <= 0xBFC00000, state <= BOOT, pend <= 0, inst_buf <= 0, redir_addr <= 0; rst overrides all inputs same edge.
REQ-033 During/after reset cycle: ibus_en = 0, if_inst = 0, if_excp = 0, if_stallreq = 1, if_pc = 0xBFC00000, if_pcp4 = 0xBFC00004.
REQ-034 rst mid-transaction (FETCH or ABORT) abandons it; next request is to 0xBFC00000 after BOOT.

Verification
REQ-035 Reset then ack every cycle, stall=0 -> ibus_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; if_inst equals ibus_rdata each cycle.
REQ-036 ack delayed 3 cycles at pc 0xBFC00004 -> ibus_en/addr held, if_stallreq=1 for 3 cycles, pc advances only after ack.
REQ-037 Ack with stall=1 for 2 cycles, rdata 0x24020001 -> HOLD, ibus_en=0, if_inst=0x24020001 held; stall drop -> next fetch pc+4.
REQ-038 br_flag=1, br_addr=0x80001000 while delay slot waits for ack -> delay slot delivered, next ibus_addr 0x80001000.
REQ-039 flush=1, flush_pc=0xBFC00380 with request outstanding -> ABORT, data on ack dropped, then fetch 0xBFC00380; flush with no outstanding request -> fetch 0xBFC00380 next cycle.
REQ-040 br_addr=0x80000002 -> no bus request, if_excp=1, if_inst=0, if_pcp4=0x80000006; pc 0xFFFFFFFC -> if_pcp4=0x00000000.
